mem_stage: RTL

- Memory stage of the 5-stage RV32I pipeline. Sits directly downstream of the execute stage and consumes its alu_result, write_data, rd, pc_plus4 and control outputs through the EX/MEM register.
- Performs load/store alignment and byte-enable generation, and drives a single-outstanding valid/ready data-memory bus.
- Stalls the pipeline while an access is in flight, then sign/zero-extends load data into an internal MEM/WB register.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_stage_lsu_align.sv | 72 +++++++
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared encodings for the memory stage
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
// ============================================================================
// lsu_align : store lane/byte-enable generation, misalign detection and
//             load extraction with sign/zero extension (combinational)
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_align
   import mem_pkg::*;
#(
   parameter int D_WIDTH = 32
) (
   input  logic               is_store,
   input  logic [2:0]         st_funct3,
   input  logic [1:0]         st_addr_lo,
   input  logic [D_WIDTH-1:0] st_data,
   output logic [3:0]         st_be,
   output logic [D_WIDTH-1:0] st_wdata,
   output logic               misalign,
   input  logic [2:0]         ld_funct3,
   input  logic [1:0]         ld_addr_lo,
   input  logic [D_WIDTH-1:0] ld_rdata,
   output logic [D_WIDTH-1:0] ld_data
);

   logic               st_is_byte;
   logic               st_is_half;
   logic [D_WIDTH-1:0] shifted;
   logic               ld_signed;

   // Only 000/100 are byte and 001/101 are half; everything else is a word.
   assign st_is_byte = (st_funct3[1:0] == F3_B[1:0]);
   assign st_is_half = (st_funct3[1:0] == F3_H[1:0]);

   always_comb begin
      st_be    = 4'b0000;
      st_wdata = '0;
      misalign = 1'b0;
      if (st_is_half) begin
         misalign = st_addr_lo[0];
      end else if (!st_is_byte) begin
         misalign = (st_addr_lo != 2'b00);
      end
      if (is_store) begin
         if (st_is_byte) begin
            st_be    = 4'b0001 << st_addr_lo;
            st_wdata = D_WIDTH'({4{st_data[7:0]}});
         end else if (st_is_half) begin
            st_be    = 4'b0011 << {st_addr_lo[1], 1'b0};
            st_wdata = D_WIDTH'({2{st_data[15:0]}});
         end else begin
            st_be    = 4'b1111;
            st_wdata = st_data;
         end
      end
   end

   assign shifted   = ld_rdata >> {ld_addr_lo, 3'b000};
   assign ld_signed = ~ld_funct3[2];

   always_comb begin
      ld_data = shifted;
      if (ld_funct3[1:0] == F3_B[1:0]) begin
         ld_data = {{(D_WIDTH-8){ld_signed & shifted[7]}}, shifted[7:0]};
      end else if (ld_funct3[1:0] == F3_H[1:0]) begin
         ld_data = {{(D_WIDTH-16){ld_signed & shifted[15]}}, shifted[15:0]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : RV32I memory stage with single-outstanding valid/ready bus,
//             access timeout and MEM/WB register
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_stage
   import mem_pkg::*;
#(
   parameter int D_WIDTH = 32,
   parameter int TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               reg_write_m_i,
   input  logic [1:0]         result_src_m_i,
   input  logic               mem_write_m_i,
   input  logic [2:0]         funct3_m_i,
   input  logic [D_WIDTH-1:0] alu_result_m_i,
   input  logic [D_WIDTH-1:0] write_data_m_i,
   input  logic [4:0]         rd_m_i,
   input  logic [D_WIDTH-1:0] pc_plus4_m_i,
   output logic               mem_req_o,
   output logic               mem_we_o,
   output logic [D_WIDTH-1:0] mem_addr_o,
   output logic [D_WIDTH-1:0] mem_wdata_o,
   output logic [3:0]         mem_be_o,
   input  logic               mem_ready_i,
   input  logic [D_WIDTH-1:0] mem_rdata_i,
   output logic               stall_o,
   output logic               misalign_o,
   output logic               bus_err_o,
   output logic               reg_write_w_o,
   output logic [1:0]         result_src_w_o,
   output logic [D_WIDTH-1:0] alu_result_w_o,
   output logic [D_WIDTH-1:0] read_data_w_o,
   output logic [4:0]         rd_w_o,
   output logic [D_WIDTH-1:0] pc_plus4_w_o
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   mem_state_t         state;
   mem_state_t         state_next;
   logic [CNT_W-1:0]   cnt;
   logic [2:0]         held_funct3;
   logic [1:0]         held_addr_lo;

   logic               access;
   logic               is_load;
   logic               misalign;
   logic [3:0]         st_be;
   logic [D_WIDTH-1:0] st_wdata;
   logic [D_WIDTH-1:0] ld_data;

   logic               issue;
   logic               complete;
   logic               timeout_hit;
   logic               wb_take;

   assign is_load = (result_src_m_i == RESULT_SRC_LOAD);
   assign access  = mem_write_m_i | is_load;

   lsu_align #(
      .D_WIDTH (D_WIDTH)
   ) u_align (
      .is_store   (mem_write_m_i),
      .st_funct3  (funct3_m_i),
      .st_addr_lo (alu_result_m_i[1:0]),
      .st_data    (write_data_m_i),
      .st_be      (st_be),
      .st_wdata   (st_wdata),
      .misalign   (misalign),
      .ld_funct3  (held_funct3),
      .ld_addr_lo (held_addr_lo),
      .ld_rdata   (mem_rdata_i),
      .ld_data    (ld_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next  = state;
      stall_o     = 1'b0;
      issue       = 1'b0;
      complete    = 1'b0;
      timeout_hit = 1'b0;
      wb_take     = 1'b0;
      case (state)
         IDLE: begin
            if (!access) begin
               wb_take = 1'b1;
            end else if (!misalign) begin
               stall_o    = 1'b1;
               issue      = 1'b1;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (mem_ready_i) begin
               complete   = 1'b1;
               wb_take    = 1'b1;
               state_next = IDLE;
            end else if (cnt == CNT_LAST) begin
               // Release the pipeline so the faulting instruction leaves as a nop.
               timeout_hit = 1'b1;
               state_next  = IDLE;
            end else begin
               stall_o = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt            <= '0;
         held_funct3    <= 3'b000;
         held_addr_lo   <= 2'b00;
         mem_req_o      <= 1'b0;
         mem_we_o       <= 1'b0;
         mem_addr_o     <= '0;
         mem_wdata_o    <= '0;
         mem_be_o       <= 4'b0000;
         misalign_o     <= 1'b0;
         bus_err_o      <= 1'b0;
         reg_write_w_o  <= 1'b0;
         result_src_w_o <= 2'b00;
         alu_result_w_o <= '0;
         read_data_w_o  <= '0;
         rd_w_o         <= 5'd0;
         pc_plus4_w_o   <= '0;
      end else begin
         misalign_o <= (state == IDLE) && access && misalign;
         bus_err_o  <= timeout_hit;

         if (issue) begin
            cnt          <= '0;
            mem_req_o    <= 1'b1;
            mem_we_o     <= mem_write_m_i;
            mem_addr_o   <= {alu_result_m_i[D_WIDTH-1:2], 2'b00};
            mem_wdata_o  <= st_wdata;
            mem_be_o     <= st_be;
            held_funct3  <= funct3_m_i;
            held_addr_lo <= alu_result_m_i[1:0];
         end else if (complete || timeout_hit) begin
            cnt       <= '0;
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            mem_be_o  <= 4'b0000;
         end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
         end

         // Anything not retiring this cycle enters writeback as a bubble.
         if (wb_take) begin
            reg_write_w_o  <= reg_write_m_i;
            result_src_w_o <= result_src_m_i;
            alu_result_w_o <= alu_result_m_i;
            read_data_w_o  <= complete ? ld_data : '0;
            rd_w_o         <= rd_m_i;
            pc_plus4_w_o   <= pc_plus4_m_i;
         end else begin
            reg_write_w_o  <= 1'b0;
            result_src_w_o <= 2'b00;
            alu_result_w_o <= '0;
            read_data_w_o  <= '0;
            rd_w_o         <= 5'd0;
            pc_plus4_w_o   <= '0;
         end
      end
   end

endmodule

`default_nettype wire
